fcu_credit_ibuf: RTL

- Receive-side counterpart of the fcu (flow control unit) in the NoC router.
- Sits at a router input port. Buffers incoming flits in a DEPTH-entry FIFO.
- Returns one credit upstream per flit popped by the local crossbar/arbiter.
- The upstream fcu's credit counter and this block's free slots therefore stay in lockstep.

---
 rtl/fcu_credit_ibuf.sv | 118 +++++++++++
 1 files changed

// File: rtl/fcu_credit_ibuf.sv
// Router input buffer that returns one credit upstream for every flit popped locally.
// Optional macro CREDIT_INIT_EN: credit_owed resets to DEPTH so DEPTH init credits go out after reset.
module fcu_credit_ibuf #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_in_valid,
    input  logic [FLIT_W-1:0] flit_in_data,
    output logic              credit_out,
    output logic              flit_out_valid,
    output logic [FLIT_W-1:0] flit_out_data,
    input  logic              flit_out_rd,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: the input side has no ready; upstream may only send while it
    // holds a credit. The output side is valid/rd: a pop happens on any edge
    // where flit_out_valid and flit_out_rd are both high; rd while empty is ignored.

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  credit_owed_q, credit_owed_d;
    logic              credit_out_q, credit_out_d;
    logic              ovf_err_q, ovf_err_d;

    logic              full_w;
    logic              empty_w;
    logic              pop_ok;
    logic              push_ok;
    logic              push_drop;
    logic [CNT_W:0]    owed_sum;

`ifdef CREDIT_INIT_EN
    localparam logic [CNT_W-1:0] CREDIT_RST = CNT_W'(DEPTH);
`else
    localparam logic [CNT_W-1:0] CREDIT_RST = '0;
`endif

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    always_comb begin
        pop_ok        = flit_out_rd && !empty_w;
        push_ok       = flit_in_valid && (!full_w || pop_ok);
        push_drop     = flit_in_valid && !push_ok;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ovf_err_d     = ovf_err_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

        // A pop on this edge can be credited on this same edge, giving 1-cycle latency.
        credit_out_d  = (credit_owed_q != '0) || pop_ok;
        owed_sum      = {1'b0, credit_owed_q} + (CNT_W + 1)'(pop_ok)
                        - (CNT_W + 1)'(credit_out_d);
        credit_owed_d = owed_sum[CNT_W-1:0];
        if (owed_sum > (CNT_W + 1)'(DEPTH)) begin
            credit_owed_d = CNT_W'(DEPTH);
            ovf_err_d     = 1'b1;
        end

        if (push_drop) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            credit_owed_q <= CREDIT_RST;
            credit_out_q  <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            credit_owed_q <= credit_owed_d;
            credit_out_q  <= credit_out_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= flit_in_data;
        end
    end

    assign flit_out_valid = !empty_w;
    assign flit_out_data  = mem_q[rd_ptr_q];
    assign credit_out     = credit_out_q;
    assign count          = count_q;
    assign full           = full_w;
    assign empty          = empty_w;
    assign ovf_err        = ovf_err_q;

endmodule
